// File: rtl/instr_format_pkg.sv
// Instruction word layout shared by the assembler and any model that needs to build or
// pick apart a 32-bit instruction.
package instr_format_pkg;

    localparam int unsigned INSTR_W   = 32;

    localparam int unsigned GROUP_MSB = 31;
    localparam int unsigned GROUP_LSB = 29;
    localparam int unsigned CMD_MSB   = 28;
    localparam int unsigned CMD_LSB   = 26;
    localparam int unsigned AT1_BIT   = 25;
    localparam int unsigned ARG1_MSB  = 24;
    localparam int unsigned ARG1_LSB  = 17;
    localparam int unsigned AT2_BIT   = 16;
    localparam int unsigned ARG2_MSB  = 15;
    localparam int unsigned ARG2_LSB  = 8;
    localparam int unsigned ADDR_MSB  = 7;
    localparam int unsigned ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } asm_state_e;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [2:0] group,
        input logic [2:0] cmd,
        input logic       at1,
        input logic [7:0] arg1,
        input logic       at2,
        input logic [7:0] arg2,
        input logic [7:0] addr
    );
        logic [INSTR_W-1:0] w;
        w                      = '0;
        w[GROUP_MSB:GROUP_LSB] = group;
        w[CMD_MSB:CMD_LSB]     = cmd;
        w[AT1_BIT]             = at1;
        w[ARG1_MSB:ARG1_LSB]   = arg1;
        w[AT2_BIT]             = at2;
        w[ARG2_MSB:ARG2_LSB]   = arg2;
        w[ADDR_MSB:ADDR_LSB]   = addr;
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding packed instruction words between acceptance and memory write.
// Push when full and pop when empty are ignored.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = (count_q == FullCount);
        empty_o = (count_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instruction_assembler.sv
// Packs decoded instruction fields into 32-bit words and writes them in order, from
// address 0, into program memory through a ready-qualified write port.
module instruction_assembler
    import instr_format_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               finish,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         command_group,
    input  logic [2:0]         command,
    input  logic               arg_type_1,
    input  logic [7:0]         arg_1,
    input  logic               arg_type_2,
    input  logic [7:0]         arg_2,
    input  logic [7:0]         address,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [7:0]         mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [8:0]         word_count
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [9:0]  MemWordsW = MEM_WORDS[9:0];

    asm_state_e         state_q, state_d;
    logic [7:0]         wptr_q, wptr_d;
    logic [8:0]         wcnt_q, wcnt_d;
    logic               ovf_q, ovf_d;

    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [CntW-1:0]    fifo_count;
    logic [INSTR_W-1:0] fifo_head, packed_word;
    logic [9:0]         capacity;
    logic               cap_full, in_load, in_flush;

    assign packed_word = pack_instr(command_group, command, arg_type_1, arg_1,
                                    arg_type_2, arg_2, address);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (packed_word),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Capacity counts words already written plus words still queued, so it is unchanged
    // by a pop and only grows on accept.
    always_comb begin
        capacity   = {1'b0, wcnt_q} + 10'(fifo_count);
        cap_full   = (capacity >= MemWordsW);
        in_load    = (state_q == StLoad);
        in_flush   = (state_q == StFlush);
        in_ready   = in_load && !fifo_full && !cap_full;
        push       = in_valid && in_ready;
        mem_we     = !fifo_empty && (in_load || in_flush);
        pop        = mem_we && mem_ready;
        mem_wdata  = mem_we ? fifo_head : '0;
        mem_addr   = wptr_q;
        busy       = in_load || in_flush;
        done       = (state_q == StDone);
        overflow   = ovf_q;
        word_count = wcnt_q;
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;

        if (pop) begin
            wptr_d = wptr_q + 8'd1;
            wcnt_d = wcnt_q + 9'd1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    wptr_d  = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            StLoad: begin
                if (in_valid && cap_full) ovf_d = 1'b1;
                // Exhaustion is seen one cycle after the last accept, which leaves a
                // window in LOAD for an excess offer to register as overflow.
                if (finish || cap_full) state_d = StFlush;
            end
            StFlush: begin
                if (fifo_empty) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: a full-size instance and a MEM_WORDS=4 instance
// share stimulus; each step checks against hand-computed words.
module tb_instruction_assembler;

    logic        clk = 1'b0;
    logic        rst, start, finish, in_valid, mem_ready;
    logic [2:0]  command_group, command;
    logic        arg_type_1, arg_type_2;
    logic [7:0]  arg_1, arg_2, address;

    logic        a_in_ready, a_mem_we, a_busy, a_done, a_overflow;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_word_count;
    logic        b_in_ready, b_mem_we, b_busy, b_done, b_overflow;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [8:0]  b_word_count;

    int tests = 0;
    int fails = 0;

    logic [2:0]  t_grp  [6] = '{3'd1, 3'd7, 3'd0, 3'd4, 3'd2, 3'd5};
    logic [2:0]  t_cmd  [6] = '{3'd2, 3'd7, 3'd0, 3'd3, 3'd5, 3'd1};
    logic        t_at1  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  t_a1   [6] = '{8'h11, 8'hFF, 8'h00, 8'h80, 8'h5A, 8'h01};
    logic        t_at2  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  t_a2   [6] = '{8'h22, 8'hFF, 8'h00, 8'h01, 8'hA5, 8'h02};
    logic [7:0]  t_addr [6] = '{8'h33, 8'hFF, 8'h01, 8'hC0, 8'h0F, 8'h03};
    logic [31:0] t_exp  [4] = '{32'h28232233, 32'hFFFFFFFF, 32'h00000001, 32'h8F0001C0};

    always #5 clk = ~clk;

    instruction_assembler #(.DEPTH(4), .MEM_WORDS(256)) u_dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(a_in_ready), .command_group(command_group), .command(command),
        .arg_type_1(arg_type_1), .arg_1(arg_1), .arg_type_2(arg_type_2), .arg_2(arg_2),
        .address(address), .mem_we(a_mem_we), .mem_ready(mem_ready),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done),
        .overflow(a_overflow), .word_count(a_word_count)
    );

    instruction_assembler #(.DEPTH(4), .MEM_WORDS(4)) u_dut_small (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(b_in_ready), .command_group(command_group), .command(command),
        .arg_type_1(arg_type_1), .arg_1(arg_1), .arg_type_2(arg_type_2), .arg_2(arg_2),
        .address(address), .mem_we(b_mem_we), .mem_ready(mem_ready),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done),
        .overflow(b_overflow), .word_count(b_word_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int k);
        command_group = t_grp[k];
        command       = t_cmd[k];
        arg_type_1    = t_at1[k];
        arg_1         = t_a1[k];
        arg_type_2    = t_at2[k];
        arg_2         = t_a2[k];
        address       = t_addr[k];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    // Holds in_valid for n cycles; fields advance each time the selected instance accepts.
    task automatic offer(input int n, input bit use_b, output int acc);
        acc = 0;
        for (int c = 0; c < n; c++) begin
            set_fields(acc);
            in_valid = 1'b1;
            if ((use_b ? b_in_ready : a_in_ready) === 1'b1) acc++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        int n;
        n = 0;
        while ((use_b ? b_done : a_done) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(use_b ? b_done : a_done), 32'd1);
    endtask

    initial begin
        int acc;
        logic [7:0]  last_addr;
        logic [31:0] last_data;

        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        set_fields(0);
        tick();
        tick();
        chk("rst_in_ready",   32'(a_in_ready),   32'd0);
        chk("rst_mem_we",     32'(a_mem_we),     32'd0);
        chk("rst_mem_addr",   32'(a_mem_addr),   32'd0);
        chk("rst_mem_wdata",  a_mem_wdata,       32'd0);
        chk("rst_busy",       32'(a_busy),       32'd0);
        chk("rst_done",       32'(a_done),       32'd0);
        chk("rst_overflow",   32'(a_overflow),   32'd0);
        chk("rst_word_count", 32'(a_word_count), 32'd0);
        rst = 1'b0;

        // Single word, latency 1 to the write port
        pulse_start();
        chk("load_busy", 32'(a_busy), 32'd1);
        chk("load_in_ready", 32'(a_in_ready), 32'd1);
        command_group = 3'b010; command = 3'b101; arg_type_1 = 1'b1; arg_1 = 8'hA5;
        arg_type_2 = 1'b0; arg_2 = 8'h3C; address = 8'h7F;
        in_valid = 1'b1; mem_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_mem_we", 32'(a_mem_we), 32'd1);
        chk("t1_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("t1_mem_wdata", a_mem_wdata, 32'h574A3C7F);
        tick();
        chk("t1_word_count", 32'(a_word_count), 32'd1);
        chk("t1_we_idle", 32'(a_mem_we), 32'd0);
        chk("t1_wdata_idle", a_mem_wdata, 32'd0);
        pulse_finish();
        wait_done(1'b0, "t1_done");

        // Backpressure: FIFO fills at 4, head held stable
        pulse_start();
        chk("t2_wc_cleared", 32'(a_word_count), 32'd0);
        mem_ready = 1'b0;
        offer(6, 1'b0, acc);
        chk("t2_accepts", 32'(acc), 32'd4);
        chk("t2_in_ready_full", 32'(a_in_ready), 32'd0);
        chk("t2_stall_we", 32'(a_mem_we), 32'd1);
        chk("t2_stall_addr", 32'(a_mem_addr), 32'd0);
        chk("t2_stall_wdata", a_mem_wdata, t_exp[0]);
        tick();
        chk("t2_hold_addr", 32'(a_mem_addr), 32'd0);
        chk("t2_hold_wdata", a_mem_wdata, t_exp[0]);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_we", 32'(a_mem_we), 32'd1);
            chk("t2_addr", 32'(a_mem_addr), 32'(k));
            chk("t2_wdata", a_mem_wdata, t_exp[k]);
            tick();
        end
        chk("t2_word_count", 32'(a_word_count), 32'd4);
        chk("t2_drained", 32'(a_mem_we), 32'd0);
        pulse_finish();
        wait_done(1'b0, "t2_done");

        // finish with words queued, start ignored in FLUSH
        pulse_start();
        mem_ready = 1'b0;
        offer(2, 1'b0, acc);
        chk("t3_accepts", 32'(acc), 32'd2);
        pulse_finish();
        chk("t3_flush_in_ready", 32'(a_in_ready), 32'd0);
        chk("t3_flush_busy", 32'(a_busy), 32'd1);
        chk("t3_flush_done", 32'(a_done), 32'd0);
        pulse_start();
        chk("t3_start_ignored", 32'(a_busy), 32'd1);
        mem_ready = 1'b1;
        chk("t3_addr0", 32'(a_mem_addr), 32'd0);
        chk("t3_wdata0", a_mem_wdata, t_exp[0]);
        tick();
        chk("t3_addr1", 32'(a_mem_addr), 32'd1);
        chk("t3_wdata1", a_mem_wdata, t_exp[1]);
        tick();
        wait_done(1'b0, "t3_done");
        chk("t3_word_count", 32'(a_word_count), 32'd2);
        chk("t3_busy_low", 32'(a_busy), 32'd0);

        // Capacity exhaustion on the MEM_WORDS=4 instance
        pulse_start();
        mem_ready = 1'b1;
        last_addr = 8'hEE;
        last_data = 32'hDEADBEEF;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            set_fields(acc);
            in_valid = 1'b1;
            if (b_in_ready === 1'b1) acc++;
            if (b_mem_we === 1'b1) begin
                last_addr = b_mem_addr;
                last_data = b_mem_wdata;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t4_accepts", 32'(acc), 32'd4);
        chk("t4_overflow", 32'(b_overflow), 32'd1);
        chk("t4_in_ready", 32'(b_in_ready), 32'd0);
        wait_done(1'b1, "t4_done");
        chk("t4_word_count", 32'(b_word_count), 32'd4);
        chk("t4_last_addr", 32'(last_addr), 32'd3);
        chk("t4_last_data", last_data, t_exp[3]);
        pulse_finish();
        wait_done(1'b0, "t4_a_done");

        // finish together with an accepted word
        pulse_start();
        chk("t5_ovf_cleared", 32'(b_overflow), 32'd0);
        set_fields(2);
        in_valid = 1'b1;
        finish = 1'b1;
        chk("t5_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        finish = 1'b0;
        chk("t5_flush_busy", 32'(a_busy), 32'd1);
        chk("t5_we", 32'(a_mem_we), 32'd1);
        chk("t5_addr", 32'(a_mem_addr), 32'd0);
        chk("t5_wdata", a_mem_wdata, t_exp[2]);
        wait_done(1'b0, "t5_done");
        chk("t5_word_count", 32'(a_word_count), 32'd1);

        // start during LOAD is ignored
        pulse_start();
        set_fields(3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_wc_before", 32'(a_word_count), 32'd1);
        pulse_start();
        chk("t5_wc_kept", 32'(a_word_count), 32'd1);
        chk("t5_still_busy", 32'(a_busy), 32'd1);
        chk("t5_not_done", 32'(a_done), 32'd0);

        // Reset mid-LOAD with 3 words queued
        mem_ready = 1'b0;
        offer(3, 1'b0, acc);
        chk("t6_accepts", 32'(acc), 32'd3);
        chk("t6_we_pre", 32'(a_mem_we), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_we", 32'(a_mem_we), 32'd0);
        chk("t6_busy", 32'(a_busy), 32'd0);
        chk("t6_done", 32'(a_done), 32'd0);
        chk("t6_in_ready", 32'(a_in_ready), 32'd0);
        chk("t6_word_count", 32'(a_word_count), 32'd0);
        chk("t6_overflow", 32'(a_overflow), 32'd0);
        chk("t6_addr", 32'(a_mem_addr), 32'd0);
        rst = 1'b0;
        pulse_start();
        mem_ready = 1'b1;
        set_fields(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6_post_we", 32'(a_mem_we), 32'd1);
        chk("t6_post_addr", 32'(a_mem_addr), 32'd0);
        chk("t6_post_wdata", a_mem_wdata, t_exp[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
